dmem_port_arbiter: RTL and testbench
====================================

// Module: dmem_port_arbiter
// PURPOSE
//  Shares the processor's single data-memory port (DataMem_*) between NUM_REQ load/store requesters.
//  Arbitration is round-robin, and each accepted request is sequenced through a 3-state FSM:
//  IDLE -> ACCESS -> RESP. Sits between the issue-side memory pipes and the Processor's
//  DataMem interface. One transaction in flight at a time.
// PARAMETERS
//  NUM_REQ     4    number of requesters (2..8)
//  DATA_W      32   address/data width
//  TIMEOUT_CYC 255  max ACCESS cycles before error completion (TIMEOUT_EN only)
// PORTS
//  clk             in   1              single clock, rising edge
//  rst             in   1              asynchronous, active-low reset
//  flush           in   1              branch flush; drop pending/unreturned work
//  req_valid       in   NUM_REQ        per-requester request valid
//  req_rw          in   NUM_REQ        per-requester 1=write, 0=read
//  req_sel         in   4*NUM_REQ      byte selects, requester i at [4i+3:4i]
//  req_addr        in   DATA_W*NUM_REQ address, requester i at slice i
//  req_wdata       in   DATA_W*NUM_REQ write data, requester i at slice i
//  req_ready       out  NUM_REQ        one-hot grant; handshake = valid&ready
//  rsp_valid       out  NUM_REQ        one-hot 1-cycle completion pulse
//  rsp_rdata       out  DATA_W         read data, valid with rsp_valid
//  rsp_err         out  1              completion was a timeout
//  DataMem_access  out  1              memory request active
//  DataMem_RW      out  1              1=write
//  DataMem_Select  out  4              byte selects
//  DataMem_Address out  DATA_W         address
//  WriteDataMem    out  DATA_W         write data
//  ReadDataMem     in   DATA_W         read data, sampled when DataMem_Ready=1
//  DataMem_Ready   in   1              memory completes the access this cycle
// BEHAVIOUR
//  Reset (rst=0, async):
//    state=IDLE; all outputs 0; rr_ptr=NUM_REQ-1, so requester 0 has top priority.
//    Reset mid-ACCESS abandons the transaction with no response.
//  IDLE:
//    req_ready is combinational: one-hot on the first valid requester searching
//    rr_ptr+1, rr_ptr+2, ... modulo NUM_REQ.
//    req_ready is all-zero if flush=1 or no requester is valid.
//    On handshake, latch id/rw/sel/addr/wdata, set rr_ptr=id, go to ACCESS.
//  ACCESS:
//    DataMem_access=1; DataMem_* are driven from the latched registers, stable until done.
//    On DataMem_Ready=1: capture ReadDataMem (0 for writes), drop access, go to RESP.
//  RESP (one cycle):
//    rsp_valid[id]=1 and rsp_rdata presented, then go to IDLE.
//    No new grant is issued in RESP.
//    Minimum spacing is 3 cycles per transaction (grant, access, resp) when Ready
//    comes in the first ACCESS cycle.
//  Flush:
//    IDLE: no grant is issued.
//    ACCESS: the memory access runs to completion (stores are never torn), but
//      a "dropped" flag is set and RESP emits no rsp_valid.
//    RESP: rsp_valid is suppressed that cycle.
//  Simultaneous events:
//    Ready and flush in the same ACCESS cycle: access completes and the response is dropped.
//    rsp_valid and a new req_valid in the same cycle: the request waits for IDLE.
//  Requesters must hold req_* stable until handshake. The arbiter never grants an
//  invalid requester.
// CONFIGURATION
//  DMEM_ARB_TIMEOUT_EN defined:
//    An 8-bit-or-wider counter clears on entry to ACCESS and increments each ACCESS cycle.
//    When the count reaches TIMEOUT_CYC without Ready: drop access, go to RESP with
//    rsp_err=1 and rsp_rdata=0. Flush still suppresses the response.
//  DMEM_ARB_TIMEOUT_EN undefined:
//    No counter; ACCESS waits indefinitely; rsp_err is tied 0.
// TESTING
//  1. Reset: rst=0 while DataMem_Ready toggles -> all outputs 0; after release with
//     req_valid=4'b1111, req_ready=4'b0001.
//  2. Round-robin: all 4 valid, Ready in the first ACCESS cycle -> grant order 0,1,2,3,0;
//     one rsp_valid every 3 cycles.
//  3. Read: req 2 reads addr 0x100, Ready after 5 cycles with ReadDataMem=0xDEADBEEF ->
//     DataMem_Address=0x100 held for 5 cycles; rsp_valid=4'b0100, rsp_rdata=0xDEADBEEF.
//  4. Flush mid-store: req 1 writes 0x55 to 0x20; flush in the 2nd ACCESS cycle; Ready in
//     the 3rd -> WriteDataMem=0x55 held to completion; no rsp_valid.
//  5. Timeout (EN, TIMEOUT_CYC=4): Ready never asserted -> access drops after 4 ACCESS
//     cycles; rsp_err=1, rsp_rdata=0.
//  6. Async reset in ACCESS -> DataMem_access=0 immediately; no rsp_valid after release.

Source files
------------

// File: rtl/dmem_port_arbiter_if.sv
// Bus bundle between the issue-side memory pipes, the arbiter and the DataMem port.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface dmem_port_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_rw;
  logic [4*NUM_REQ-1:0]      req_sel;
  logic [DATA_W*NUM_REQ-1:0] req_addr;
  logic [DATA_W*NUM_REQ-1:0] req_wdata;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_rdata;
  logic                      rsp_err;
  logic                      DataMem_access;
  logic                      DataMem_RW;
  logic [3:0]                DataMem_Select;
  logic [DATA_W-1:0]         DataMem_Address;
  logic [DATA_W-1:0]         WriteDataMem;
  logic [DATA_W-1:0]         ReadDataMem;
  logic                      DataMem_Ready;

  modport slave (
    input  req_valid, req_rw, req_sel, req_addr, req_wdata, ReadDataMem, DataMem_Ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           DataMem_access, DataMem_RW, DataMem_Select, DataMem_Address, WriteDataMem
  );

  modport master (
    output req_valid, req_rw, req_sel, req_addr, req_wdata, ReadDataMem, DataMem_Ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           DataMem_access, DataMem_RW, DataMem_Select, DataMem_Address, WriteDataMem
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter sharing one DataMem port among NUM_REQ requesters (IDLE->ACCESS->RESP).
// Optional access timeout compiled in with `define DMEM_ARB_TIMEOUT_EN.
module dmem_port_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  dmem_port_arbiter_if.slave bus
);
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t             state;
  logic [IDW-1:0]     rr_ptr;
  logic [IDW-1:0]     cur_id;
  logic               rw_q;
  logic [3:0]         sel_q;
  logic [DATA_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic               acc_q;
  logic               dropped;
  logic [NUM_REQ-1:0] rsp_vld_q;
  logic               err_q;
  logic [DATA_W-1:0]  rdata_q;

  logic [NUM_REQ-1:0] gnt;
  logic [IDW-1:0]     gnt_id;
  logic [IDW-1:0]     idx;
  logic               gnt_any;
  logic               to_hit;

`ifdef DMEM_ARB_TIMEOUT_EN
  localparam int TW = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
  logic [TW-1:0] to_cnt;

  // Count is zero in the first ACCESS cycle, so the hit lands on cycle TIMEOUT_CYC.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                 to_cnt <= '0;
    else if (state == IDLE)   to_cnt <= '0;
    else if (state == ACCESS) to_cnt <= to_cnt + TW'(1);
  end

  assign to_hit = (to_cnt == TW'(TIMEOUT_CYC - 1));
`else
  // Without the timeout the access waits for Ready indefinitely.
  assign to_hit = (TIMEOUT_CYC < 0);
`endif

  // Search starts just after the last winner so every requester gets a turn.
  always_comb begin
    gnt     = '0;
    gnt_id  = rr_ptr;
    gnt_any = 1'b0;
    idx     = '0;
    if (state == IDLE && !flush) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        idx = IDW'((int'(rr_ptr) + k) % NUM_REQ);
        if (!gnt_any && bus.req_valid[idx]) begin
          gnt[idx] = 1'b1;
          gnt_id   = idx;
          gnt_any  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      rr_ptr    <= IDW'(NUM_REQ - 1);
      cur_id    <= '0;
      rw_q      <= 1'b0;
      sel_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      acc_q     <= 1'b0;
      dropped   <= 1'b0;
      rsp_vld_q <= '0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_any) begin
            cur_id  <= gnt_id;
            rr_ptr  <= gnt_id;
            rw_q    <= bus.req_rw[gnt_id];
            sel_q   <= bus.req_sel[gnt_id*4 +: 4];
            addr_q  <= bus.req_addr[gnt_id*DATA_W +: DATA_W];
            wdata_q <= bus.req_wdata[gnt_id*DATA_W +: DATA_W];
            acc_q   <= 1'b1;
            dropped <= 1'b0;
            state   <= ACCESS;
          end
        end
        ACCESS: begin
          // A flushed store still completes on the bus; only its response is dropped.
          if (flush) dropped <= 1'b1;
          if (bus.DataMem_Ready || to_hit) begin
            acc_q     <= 1'b0;
            rdata_q   <= (bus.DataMem_Ready && !rw_q) ? bus.ReadDataMem : '0;
            err_q     <= !bus.DataMem_Ready && !(dropped || flush);
            rsp_vld_q <= (dropped || flush) ? '0 : (NUM_REQ'(1) << cur_id);
            state     <= RESP;
          end
        end
        RESP: begin
          rsp_vld_q <= '0;
          err_q     <= 1'b0;
          rdata_q   <= '0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready       = gnt;
  assign bus.rsp_valid       = rsp_vld_q & {NUM_REQ{~flush}};
  assign bus.rsp_err         = err_q & ~flush;
  assign bus.rsp_rdata       = rdata_q;
  assign bus.DataMem_access  = acc_q;
  assign bus.DataMem_RW      = rw_q;
  assign bus.DataMem_Select  = sel_q;
  assign bus.DataMem_Address = addr_q;
  assign bus.WriteDataMem    = wdata_q;
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed and randomized bench for dmem_port_arbiter against a transaction-level model.
module tb_dmem_port_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;
  logic flush;

  dmem_port_arbiter_if #(.NUM_REQ(N), .DATA_W(DW)) bus();

  dmem_port_arbiter #(.NUM_REQ(N), .DATA_W(DW), .TIMEOUT_CYC(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .flush(flush),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  int last_gnt;
  int got_id;
  int last_rsp_cyc;

  logic        rw_a   [N];
  logic [3:0]  sel_a  [N];
  logic [31:0] addr_a [N];
  logic [31:0] wd_a   [N];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic rand_reqs;
    for (int i = 0; i < N; i++) begin
      rw_a[i]   = 1'($urandom_range(0, 1));
      sel_a[i]  = 4'($urandom);
      addr_a[i] = $urandom;
      wd_a[i]   = $urandom;
    end
  endtask

  task automatic drive_reqs(input logic [N-1:0] mask);
    for (int i = 0; i < N; i++) begin
      bus.req_rw[i]            = rw_a[i];
      bus.req_sel[4*i +: 4]    = sel_a[i];
      bus.req_addr[DW*i +: DW] = addr_a[i];
      bus.req_wdata[DW*i +: DW] = wd_a[i];
    end
    bus.req_valid = mask;
  endtask

  // Winner is the valid requester at the shortest rotational distance past the last winner.
  function automatic int model_pick(input logic [N-1:0] mask, input int last);
    int best  = -1;
    int bestd = N;
    for (int i = 0; i < N; i++) begin
      if (mask[i]) begin
        int d = (i - last - 1 + 2*N) % N;
        if (d < bestd) begin
          bestd = d;
          best  = i;
        end
      end
    end
    return best;
  endfunction

  task automatic txn(input logic [N-1:0] mask, input int lat, input int flush_at,
                     input bit resp_flush, input logic [31:0] rd);
    int id;
    logic [N-1:0] oh;
    bit dropped;
    drive_reqs(mask);
    #1;
    id = model_pick(mask, last_gnt);
    oh = N'(1) << id;
    chk("grant", 64'(bus.req_ready), 64'(oh));
    got_id = id;
    tick;
    last_gnt = id;
    for (int c = 1; c <= lat + 1; c++) begin
      chk("access_on", 64'(bus.DataMem_access), 64'd1);
      chk("addr",      64'(bus.DataMem_Address), 64'(addr_a[id]));
      chk("rw",        64'(bus.DataMem_RW), 64'(rw_a[id]));
      chk("sel",       64'(bus.DataMem_Select), 64'(sel_a[id]));
      chk("wdata",     64'(bus.WriteDataMem), 64'(wd_a[id]));
      flush             = (c == flush_at);
      bus.DataMem_Ready = (c == lat + 1);
      bus.ReadDataMem   = rd;
      #1;
      chk("no_grant_access", 64'(bus.req_ready), 64'd0);
      tick;
    end
    flush             = 1'b0;
    bus.DataMem_Ready = 1'b0;
    bus.ReadDataMem   = $urandom;
    dropped = (flush_at != 0);
    chk("access_off", 64'(bus.DataMem_access), 64'd0);
    chk("rsp_valid",  64'(bus.rsp_valid), dropped ? 64'd0 : 64'(oh));
    chk("rsp_err",    64'(bus.rsp_err), 64'd0);
    if (!dropped) begin
      chk("rsp_rdata", 64'(bus.rsp_rdata), rw_a[id] ? 64'd0 : 64'(rd));
      last_rsp_cyc = cyc;
    end
    chk("no_grant_resp", 64'(bus.req_ready), 64'd0);
    if (resp_flush) begin
      flush = 1'b1;
      #1;
      chk("rsp_flushed", 64'(bus.rsp_valid), 64'd0);
      flush = 1'b0;
    end
    bus.req_valid = '0;
    tick;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int prev;
    logic [N-1:0] m;
    int lat;
    int fa;

    rst = 1'b1;
    flush = 1'b0;
    bus.req_valid = '0; bus.req_rw = '0; bus.req_sel = '0;
    bus.req_addr = '0; bus.req_wdata = '0;
    bus.ReadDataMem = '0; bus.DataMem_Ready = 1'b0;
    rand_reqs();
    #1;
    rst = 1'b0;

    // reset holds everything at zero while Ready toggles
    for (int i = 0; i < 4; i++) begin
      bus.DataMem_Ready = i[0];
      bus.ReadDataMem   = $urandom;
      tick;
      chk("rst_access", 64'(bus.DataMem_access), 64'd0);
      chk("rst_rsp",    64'(bus.rsp_valid), 64'd0);
      chk("rst_rdata",  64'(bus.rsp_rdata), 64'd0);
      chk("rst_addr",   64'(bus.DataMem_Address), 64'd0);
      chk("rst_ready",  64'(bus.req_ready), 64'd0);
    end
    bus.DataMem_Ready = 1'b0;
    rst = 1'b1;
    last_gnt = N - 1;
    drive_reqs(4'b1111);
    #1;
    chk("post_rst_grant", 64'(bus.req_ready), 64'b0001);

    // round robin with immediate Ready
    prev = 0;
    for (int k = 0; k < 5; k++) begin
      rand_reqs();
      txn(4'b1111, 0, 0, 1'b0, $urandom);
      chk("rr_order", 64'(got_id), 64'(k % 4));
      if (k > 0) chk("rsp_spacing", 64'(last_rsp_cyc - prev), 64'd3);
      prev = last_rsp_cyc;
    end

    // slow read from requester 2
    rand_reqs();
    rw_a[2] = 1'b0; addr_a[2] = 32'h100;
    txn(4'b0100, 4, 0, 1'b0, 32'hDEADBEEF);

    // store flushed mid-access still completes
    rand_reqs();
    rw_a[1] = 1'b1; addr_a[1] = 32'h20; wd_a[1] = 32'h55;
    txn(4'b0010, 2, 2, 1'b0, $urandom);

    // flush coincident with Ready, then flush during RESP
    rand_reqs();
    txn(4'b1001, 0, 1, 1'b0, $urandom);
    rand_reqs();
    txn(4'b0110, 1, 0, 1'b1, $urandom);

    // flush in IDLE blocks the grant
    rand_reqs();
    flush = 1'b1;
    drive_reqs(4'b1111);
    #1;
    chk("idle_flush_grant", 64'(bus.req_ready), 64'd0);
    tick;
    chk("idle_flush_access", 64'(bus.DataMem_access), 64'd0);
    flush = 1'b0;
    bus.req_valid = '0;

`ifdef DMEM_ARB_TIMEOUT_EN
    rand_reqs();
    rw_a[3] = 1'b0;
    drive_reqs(4'b1000);
    #1;
    chk("to_grant", 64'(bus.req_ready), 64'(N'(1) << model_pick(4'b1000, last_gnt)));
    tick;
    last_gnt = 3;
    bus.req_valid = '0;
    bus.ReadDataMem = 32'hA5A5A5A5;
    for (int c = 0; c < 4; c++) begin
      chk("to_access_on", 64'(bus.DataMem_access), 64'd1);
      tick;
    end
    chk("to_access_off", 64'(bus.DataMem_access), 64'd0);
    chk("to_rsp_valid",  64'(bus.rsp_valid), 64'b1000);
    chk("to_rsp_err",    64'(bus.rsp_err), 64'd1);
    chk("to_rsp_rdata",  64'(bus.rsp_rdata), 64'd0);
    tick;
`endif

    // randomized traffic
    for (int t = 0; t < 40; t++) begin
      rand_reqs();
      m   = N'($urandom_range(1, (1 << N) - 1));
      lat = $urandom_range(0, 3);
      fa  = ($urandom_range(0, 4) == 0) ? $urandom_range(1, lat + 1) : 0;
      txn(m, lat, fa, ($urandom_range(0, 7) == 0), $urandom);
    end

    // asynchronous reset during ACCESS abandons the transfer
    rand_reqs();
    drive_reqs(4'b0100);
    #1;
    tick;
    bus.req_valid = '0;
    chk("ar_access_on", 64'(bus.DataMem_access), 64'd1);
    #1;
    rst = 1'b0;
    #1;
    chk("ar_access_off", 64'(bus.DataMem_access), 64'd0);
    tick;
    tick;
    rst = 1'b1;
    last_gnt = N - 1;
    for (int c = 0; c < 3; c++) begin
      bus.DataMem_Ready = 1'b1;
      tick;
      chk("ar_no_rsp", 64'(bus.rsp_valid), 64'd0);
    end
    bus.DataMem_Ready = 1'b0;
    drive_reqs(4'b1111);
    #1;
    chk("ar_grant", 64'(bus.req_ready), 64'(N'(1) << model_pick(4'b1111, last_gnt)));
    bus.req_valid = '0;
    tick;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
